cpu_axi_master: RTL
===================

# cpu_axi_master

Bus master bridge between the MIPS core's memory port and `axi_interconnect`. Turns one single-beat CPU load/store request into an AXI4-Lite write (AW+W, then B) or read (AR, then R) on the interconnect's master-side port, and stalls the core until the transaction completes. A transaction-timeout watchdog aborts hung transactions and flags them to the core.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, 256: per-transaction cycle limit; 0 disables the watchdog.
- `ERR_RDATA`, 32'h0000_0000: value returned on `cpu_data_o` for a timed-out read.

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  reset; synchronous, active-high (`RstEnable` = 1'b1).
- `cpu_ce_i`  in  1  request valid; held with its other request fields while `cpu_stall_o`=1.
- `cpu_we_i`  in  1  1 = store, 0 = load.
- `cpu_addr_i`  in  32  byte address, passed unmodified.
- `cpu_sel_i`  in  4  byte enables for stores.
- `cpu_data_i`  in  32  store data.
- `cpu_data_o`  out  32  load data, registered.
- `cpu_stall_o`  out  1  core must hold the request.
- `cpu_err_o`  out  1  one-cycle pulse: transaction aborted by timeout.
- `M_AXI_AWADDR` out 32, `M_AXI_AWVALID` out 1, `M_AXI_AWREADY` in 1.
- `M_AXI_WDATA` out 32, `M_AXI_WSTRB` out 4, `M_AXI_WVALID` out 1, `M_AXI_WREADY` in 1.
- `M_AXI_BVALID` in 1, `M_AXI_BREADY` out 1.
- `M_AXI_ARADDR` out 32, `M_AXI_ARVALID` out 1, `M_AXI_ARREADY` in 1.
- `M_AXI_RDATA` in 32, `M_AXI_RVALID` in 1, `M_AXI_RREADY` out 1.

## Operation
- FSM states: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, DONE.
- IDLE and `cpu_ce_i`=1: register addr, data and strobes. Go to WR_REQ with AWVALID=WVALID=1 if `cpu_we_i`, otherwise to RD_REQ with ARVALID=1.
- WR_REQ: AW and W handshake independently, in the same cycle or in different cycles. Each VALID drops the cycle after its own handshake. Internal `aw_done` and `w_done` flags track completion. Once both are complete (the completing cycle counts), go to WR_RESP with BREADY=1.
- WR_RESP: on BVALID&&BREADY, drop BREADY and go to DONE.
- RD_REQ: on ARVALID&&ARREADY, drop ARVALID, go to RD_RESP with RREADY=1.
- RD_RESP: on RVALID&&RREADY, capture RDATA into `cpu_data_o`, drop RREADY, go to DONE.
- DONE: lasts one cycle with `cpu_stall_o`=0, so the core retires the request. Then go to IDLE.
- `cpu_stall_o` is combinational: it is 1 in WR_REQ/WR_RESP/RD_REQ/RD_RESP, 1 in IDLE when `cpu_ce_i`=1, 0 otherwise, and forced 0 while `rst`=1.
- `cpu_ce_i` dropping mid-transaction is ignored. An accepted transaction always runs to DONE.
- AXI outputs are registered. ADDR/DATA/STRB stay stable while the matching VALID is high and keep their last value after it.
- `cpu_data_o` keeps the last read data until the next read completes or times out. Writes do not change it.
- Watchdog:
  - The counter clears on leaving IDLE and increments every cycle spent in the four wait states.
  - If it reaches `TIMEOUT_CYCLES`-1 in a cycle where the pending handshake does not complete, force all VALID/READY outputs to 0. Then go to DONE with `cpu_err_o`=1 for that DONE cycle, and load `cpu_data_o` with `ERR_RDATA` if the transaction was a read.
  - A handshake completing in the same cycle as the limit wins; no error is raised.
  - Abort deliberately violates the AXI VALID-hold rule; it is a debug and recovery path only.

## Timing
- Reset (`rst`=1 at a clock edge):
  - State goes to IDLE.
  - All VALID/READY outputs, AWADDR, ARADDR, WDATA, WSTRB, `cpu_data_o` and `cpu_err_o` go to 0.
  - The watchdog counter and the `aw_done`/`w_done` flags clear.
  - This applies mid-transaction as well; the outstanding AXI transaction is dropped.
- Request at cycle 0, with zero-wait slaves responding in the first cycle their channel is driven:
  - VALIDs are high in cycle 1, which is the address/data handshake.
  - BREADY or RREADY is high in cycle 2, which is the response handshake.
  - DONE is cycle 3, so `cpu_stall_o`=0 in cycle 3. Minimum latency is 3 cycles for both loads and stores.
- Each slave wait cycle adds one cycle.
- A back-to-back request presented in the cycle after DONE is accepted immediately; there are no idle bubbles beyond IDLE's one cycle.
- No more than one outstanding transaction. AW/W and AR are never active together.

## Test plan
- Store `addr`=32'h1000_0004, `sel`=4'b0011, `data`=32'hCAFE_BABE, all slaves zero-wait -> AWADDR=32'h1000_0004, WSTRB=4'b0011, WDATA=32'hCAFE_BABE in cycle 1; BREADY in cycle 2; `cpu_stall_o`=0 in cycle 3.
- Load `addr`=32'h2000_0010, slave returns RDATA=32'h1234_5678 after 4 wait cycles -> `cpu_data_o`=32'h1234_5678 in DONE at cycle 7; stall high in cycles 0-6.
- Store with AWREADY delayed 3 cycles and WREADY immediate -> WVALID drops after cycle 1, AWVALID drops after cycle 4, BREADY rises in cycle 5, no duplicate W beat.
- Load with `TIMEOUT_CYCLES`=8 and no ARREADY -> ARVALID forced low after 8 wait cycles, DONE with `cpu_err_o`=1 for exactly one cycle, `cpu_data_o`=`ERR_RDATA`.
- Assert `rst` in WR_RESP -> next cycle all outputs are 0 and state is IDLE. A following load completes normally in 3 cycles.
- `cpu_ce_i` dropped in cycle 2 of a read -> transaction still completes, and `cpu_data_o` updates in DONE.

Source files
------------

// File: rtl/cpu_axi_master.sv
// cpu_axi_master: bridges one single-beat CPU load/store into an AXI4-Lite
// write (AW+W then B) or read (AR then R), stalling the core until the
// transaction retires. A watchdog aborts transactions that hang.
module cpu_axi_master #(
  parameter int unsigned TIMEOUT_CYCLES = 256,
  parameter logic [31:0] ERR_RDATA      = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  // CPU memory port
  input  logic        cpu_ce_i,
  input  logic        cpu_we_i,
  input  logic [31:0] cpu_addr_i,
  input  logic [3:0]  cpu_sel_i,
  input  logic [31:0] cpu_data_i,
  output logic [31:0] cpu_data_o,
  output logic        cpu_stall_o,
  output logic        cpu_err_o,
  // AXI4-Lite write address channel
  output logic [31:0] M_AXI_AWADDR,
  output logic        M_AXI_AWVALID,
  input  logic        M_AXI_AWREADY,
  // AXI4-Lite write data channel
  output logic [31:0] M_AXI_WDATA,
  output logic [3:0]  M_AXI_WSTRB,
  output logic        M_AXI_WVALID,
  input  logic        M_AXI_WREADY,
  // AXI4-Lite write response channel
  input  logic        M_AXI_BVALID,
  output logic        M_AXI_BREADY,
  // AXI4-Lite read address channel
  output logic [31:0] M_AXI_ARADDR,
  output logic        M_AXI_ARVALID,
  input  logic        M_AXI_ARREADY,
  // AXI4-Lite read data channel
  input  logic [31:0] M_AXI_RDATA,
  input  logic        M_AXI_RVALID,
  output logic        M_AXI_RREADY
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WR_REQ  = 3'd1,
    S_WR_RESP = 3'd2,
    S_RD_REQ  = 3'd3,
    S_RD_RESP = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  // Watchdog fires once the counter reaches the last permitted wait cycle.
  // A counter past the limit (possible after a handshake won at the limit)
  // still counts as expired, so the next stalled phase aborts immediately.
  localparam logic [31:0] LP_LIMIT =
    (TIMEOUT_CYCLES == 32'd0) ? 32'd0 : (TIMEOUT_CYCLES - 32'd1);

  state_t      r_state;
  logic        r_aw_done;
  logic        r_w_done;
  logic [31:0] r_wdog;
  logic [31:0] r_awaddr;
  logic        r_awvalid;
  logic [31:0] r_wdata;
  logic [3:0]  r_wstrb;
  logic        r_wvalid;
  logic        r_bready;
  logic [31:0] r_araddr;
  logic        r_arvalid;
  logic        r_rready;
  logic [31:0] r_data;
  logic        r_err;

  logic w_aw_hs;
  logic w_w_hs;
  logic w_b_hs;
  logic w_ar_hs;
  logic w_r_hs;
  logic w_aw_all;
  logic w_w_all;
  logic w_timeout;
  logic w_stall;

  assign w_aw_hs   = r_awvalid & M_AXI_AWREADY;
  assign w_w_hs    = r_wvalid  & M_AXI_WREADY;
  assign w_b_hs    = r_bready  & M_AXI_BVALID;
  assign w_ar_hs   = r_arvalid & M_AXI_ARREADY;
  assign w_r_hs    = r_rready  & M_AXI_RVALID;
  // "Completing" includes a handshake happening in the current cycle.
  assign w_aw_all  = r_aw_done | w_aw_hs;
  assign w_w_all   = r_w_done  | w_w_hs;
  assign w_timeout = (TIMEOUT_CYCLES != 32'd0) && (r_wdog >= LP_LIMIT);

  // Transaction FSM with registered AXI outputs, watchdog and load data.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
      r_wdog    <= 32'd0;
      r_awaddr  <= 32'd0;
      r_awvalid <= 1'b0;
      r_wdata   <= 32'd0;
      r_wstrb   <= 4'd0;
      r_wvalid  <= 1'b0;
      r_bready  <= 1'b0;
      r_araddr  <= 32'd0;
      r_arvalid <= 1'b0;
      r_rready  <= 1'b0;
      r_data    <= 32'd0;
      r_err     <= 1'b0;
    end else begin
      r_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (cpu_ce_i) begin
            r_wdog    <= 32'd0;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
            if (cpu_we_i) begin
              r_awaddr  <= cpu_addr_i;
              r_wdata   <= cpu_data_i;
              r_wstrb   <= cpu_sel_i;
              r_awvalid <= 1'b1;
              r_wvalid  <= 1'b1;
              r_state   <= S_WR_REQ;
            end else begin
              r_araddr  <= cpu_addr_i;
              r_arvalid <= 1'b1;
              r_state   <= S_RD_REQ;
            end
          end
        end
        S_WR_REQ: begin
          r_wdog <= r_wdog + 32'd1;
          if (w_aw_hs) begin
            r_awvalid <= 1'b0;
            r_aw_done <= 1'b1;
          end
          if (w_w_hs) begin
            r_wvalid <= 1'b0;
            r_w_done <= 1'b1;
          end
          if (w_aw_all && w_w_all) begin
            r_bready <= 1'b1;
            r_state  <= S_WR_RESP;
          end else if (w_timeout) begin
            r_awvalid <= 1'b0;
            r_wvalid  <= 1'b0;
            r_err     <= 1'b1;
            r_state   <= S_DONE;
          end
        end
        S_WR_RESP: begin
          r_wdog <= r_wdog + 32'd1;
          if (w_b_hs) begin
            r_bready <= 1'b0;
            r_state  <= S_DONE;
          end else if (w_timeout) begin
            r_bready <= 1'b0;
            r_err    <= 1'b1;
            r_state  <= S_DONE;
          end
        end
        S_RD_REQ: begin
          r_wdog <= r_wdog + 32'd1;
          if (w_ar_hs) begin
            r_arvalid <= 1'b0;
            r_rready  <= 1'b1;
            r_state   <= S_RD_RESP;
          end else if (w_timeout) begin
            r_arvalid <= 1'b0;
            r_data    <= ERR_RDATA;
            r_err     <= 1'b1;
            r_state   <= S_DONE;
          end
        end
        S_RD_RESP: begin
          r_wdog <= r_wdog + 32'd1;
          if (w_r_hs) begin
            r_data   <= M_AXI_RDATA;
            r_rready <= 1'b0;
            r_state  <= S_DONE;
          end else if (w_timeout) begin
            r_rready <= 1'b0;
            r_data   <= ERR_RDATA;
            r_err    <= 1'b1;
            r_state  <= S_DONE;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Stall decode: held through the wait states, and in IDLE while a request
  // is pending; never asserted while in reset.
  always_comb begin
    w_stall = 1'b0;
    if (rst) begin
      w_stall = 1'b0;
    end else begin
      case (r_state)
        S_WR_REQ, S_WR_RESP, S_RD_REQ, S_RD_RESP: w_stall = 1'b1;
        S_IDLE:                                   w_stall = cpu_ce_i;
        default:                                  w_stall = 1'b0;
      endcase
    end
  end

  assign cpu_data_o    = r_data;
  assign cpu_stall_o   = w_stall;
  assign cpu_err_o     = r_err;
  assign M_AXI_AWADDR  = r_awaddr;
  assign M_AXI_AWVALID = r_awvalid;
  assign M_AXI_WDATA   = r_wdata;
  assign M_AXI_WSTRB   = r_wstrb;
  assign M_AXI_WVALID  = r_wvalid;
  assign M_AXI_BREADY  = r_bready;
  assign M_AXI_ARADDR  = r_araddr;
  assign M_AXI_ARVALID = r_arvalid;
  assign M_AXI_RREADY  = r_rready;

endmodule
